// File: rtl/mem_port_arbiter.sv
// Two-client arbiter for the single main-memory port: port 0 = instruction cache,
// port 1 = data cache. Reads refill a 4-word line, writes are single-word write-through.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk_100,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic              done0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic              done1,

    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rword,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        state_dbg
);

    // Handshake: a client raises req with we/addr/wdata stable and holds them until
    // its one-cycle done pulse; fields are latched on the grant edge, so later input
    // changes (including dropping req) do not affect the transaction in flight.

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LAT - 1);
    localparam logic [1:0]       LAST_WORD = 2'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               owner;
    logic               last_owner;
    logic               we_q;
    logic [ADDR_W-1:0]  base_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [1:0]         word;
    logic [LAT_W-1:0]   lat;
    logic               gnt_q;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [1:0]         rword_q;

    logic               req_any;
    logic               sel;
    logic               lat_last;

    assign req_any  = req0 | req1;
    assign lat_last = (lat == LAT_LAST);

    // Single requester wins outright; on a conflict the port that did not own last wins.
    always_comb begin
        sel = 1'b0;
        if (req0 && req1) begin
            sel = ~last_owner;
        end else if (req1) begin
            sel = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_last && (we_q || (word == LAST_WORD))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            we_q       <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            word       <= '0;
            lat        <= '0;
            gnt_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rword_q    <= '0;
        end else begin
            state    <= state_nxt;
            rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner      <= sel;
                        last_owner <= sel;
                        we_q       <= sel ? we1 : we0;
                        base_q     <= sel ? addr1 : addr0;
                        wdata_q    <= sel ? wdata1 : wdata0;
                        word       <= '0;
                        lat        <= '0;
                        gnt_q      <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (lat_last) begin
                        lat <= '0;
                        if (!we_q) begin
                            rdata_q  <= mem_rdata;
                            rword_q  <= word;
                            rvalid_q <= 1'b1;
                            word     <= word + 2'd1;
                        end
                    end else begin
                        lat <= lat + LAT_W'(1);
                    end
                end
                DONE: begin
                    gnt_q <= 1'b0;
                end
                default: begin
                    gnt_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory-side drive is purely a function of state so reset silences it at once.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (state == ACCESS) begin
            if (we_q) begin
                mem_addr  = base_q;
                mem_wdata = wdata_q;
                mem_we    = 1'b1;
            end else begin
                mem_addr = {base_q[ADDR_W-1:2], word};
            end
        end
    end

    assign gnt0      = gnt_q & ~owner;
    assign gnt1      = gnt_q & owner;
    assign rvalid0   = rvalid_q & ~owner;
    assign rvalid1   = rvalid_q & owner;
    assign done0     = (state == DONE) & ~owner;
    assign done1     = (state == DONE) & owner;
    assign rdata     = rdata_q;
    assign rword     = rword_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: refills, write-through, round-robin,
// mid-burst reset and owner input changes after the grant edge.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 4;

    logic        clk_100;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, rvalid0, done0, gnt1, rvalid1, done1;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  rword, state_dbg;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT), .LINE_WORDS(4)) dut (
        .clk_100(clk_100), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .done1(done1),
        .rdata(rdata), .rword(rword),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .state_dbg(state_dbg)
    );

    // Memory model: every word reads back as 16'hA000 + its address.
    assign mem_rdata = 16'hA000 + mem_addr;

    initial begin
        clk_100 = 1'b0;
        forever #5 clk_100 = ~clk_100;
    end

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_gnt0"}, gnt0, 1'b0);
        check1({tag, "_gnt1"}, gnt1, 1'b0);
        check1({tag, "_rvalid0"}, rvalid0, 1'b0);
        check1({tag, "_rvalid1"}, rvalid1, 1'b0);
        check1({tag, "_done0"}, done0, 1'b0);
        check1({tag, "_done1"}, done1, 1'b0);
        check1({tag, "_mem_we"}, mem_we, 1'b0);
        check16({tag, "_mem_addr"}, mem_addr, 16'h0000);
        check16({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
        check16({tag, "_rdata"}, rdata, 16'h0000);
        check2({tag, "_rword"}, rword, 2'd0);
        check2({tag, "_state"}, state_dbg, 2'd0);
    endtask

    // Starts on the cycle before the req-sampling edge; ends in the idle cycle after done.
    task automatic txn(input logic port, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic drop, input logic disturb);
        int n;
        logic [1:0]  w;
        logic [1:0]  w_cap;
        logic [15:0] exp_addr;
        logic        rv_exp;
        n = we ? MEM_LAT + 1 : 4 * MEM_LAT + 1;
        tick();
        for (int k = 1; k <= n; k++) begin
            w = 2'((k - 1) / MEM_LAT);
            check1("gnt_own", port ? gnt1 : gnt0, 1'b1);
            check1("gnt_other", port ? gnt0 : gnt1, 1'b0);
            if (k < n) begin
                exp_addr = we ? addr : {addr[15:2], w};
                check16("mem_addr", mem_addr, exp_addr);
                check1("mem_we", mem_we, we);
                check16("mem_wdata", mem_wdata, we ? wdata : 16'h0000);
                check2("state_access", state_dbg, 2'd1);
            end else begin
                check16("done_mem_addr", mem_addr, 16'h0000);
                check1("done_mem_we", mem_we, 1'b0);
                check2("state_done", state_dbg, 2'd2);
            end
            rv_exp = !we && (k > 1) && (((k - 1) % MEM_LAT) == 0);
            check1("rvalid_own", port ? rvalid1 : rvalid0, rv_exp);
            check1("rvalid_other", port ? rvalid0 : rvalid1, 1'b0);
            if (rv_exp) begin
                w_cap = 2'((k - 2) / MEM_LAT);
                check16("rdata", rdata, 16'hA000 + {addr[15:2], w_cap});
                check2("rword", rword, w_cap);
            end
            check1("done_own", port ? done1 : done0, k == n);
            check1("done_other", port ? done0 : done1, 1'b0);
            if (disturb && k == 6) begin
                if (port) begin
                    req1 = 1'b0; we1 = 1'b1; addr1 = ~addr1; wdata1 = 16'h1111;
                end else begin
                    req0 = 1'b0; we0 = 1'b1; addr0 = ~addr0; wdata0 = 16'h1111;
                end
            end
            if (drop && k == n) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
        end
        check1("idle_gnt0", gnt0, 1'b0);
        check1("idle_gnt1", gnt1, 1'b0);
        check16("idle_mem_addr", mem_addr, 16'h0000);
        check16("idle_mem_wdata", mem_wdata, 16'h0000);
        check2("idle_state", state_dbg, 2'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Port 0 line refill alone
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h1237;
        txn(1'b0, 1'b0, 16'h1237, 16'h0000, 1'b1, 1'b0);

        // Port 1 write-through
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h00F2; wdata1 = 16'hBEEF;
        txn(1'b1, 1'b1, 16'h00F2, 16'hBEEF, 1'b1, 1'b0);

        // Conflict straight out of reset: port 0 first, then port 1 after one idle cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0081;
        txn(1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 16'h0081, 16'h0000, 1'b0, 1'b0);

        // Both keep requesting writes: winner keeps alternating 0, 1, 0
        we0 = 1'b1; addr0 = 16'h0A00; wdata0 = 16'h1234;
        we1 = 1'b1; addr1 = 16'h0B01; wdata1 = 16'h5678;
        txn(1'b0, 1'b1, 16'h0A00, 16'h1234, 1'b0, 1'b0);
        txn(1'b1, 1'b1, 16'h0B01, 16'h5678, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 16'h0A00, 16'h1234, 1'b1, 1'b0);

        // Reset during word 2 of a port 1 refill, then restart from word 0
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0300;
        tick();
        for (int i = 0; i < 9; i++) tick();
        check16("pre_reset_addr", mem_addr, 16'h0302);
        check1("pre_reset_gnt1", gnt1, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        tick();
        check1("midreset_done1", done1, 1'b0);
        rst = 1'b0;
        txn(1'b1, 1'b0, 16'h0300, 16'h0000, 1'b1, 1'b0);

        // Owner drops req and changes address mid-burst
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h5550;
        txn(1'b0, 1'b0, 16'h5550, 16'h0000, 1'b1, 1'b1);
        tick();
        check2("final_idle", state_dbg, 2'd0);
        check1("final_gnt0", gnt0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
